// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchronised serial input, mid-bit sampling,
// one-cycle data_valid / frame_err strobes and a break-safe WAIT_HIGH state.
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  // The IDLE detect cycle is the first of the half period, so START counts HALF-1 more.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 2);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    if (!ena) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: table of frames, hand-written corner
// sequences and random frames scored against a frame-level expectation queue.
module tb_uart_rx_8n1;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level model state: bytes still owed, frame errors owed, last good byte.
  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  int exp_ferr    = 0;
  int ferr_seen   = 0;
  int extra_valid = 0;
  int bad_strobe  = 0;
  int valid_cyc   = 0;
  int stop_cyc    = 0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap_bits;
    logic       exp_valid;
    logic [7:0] exp_byte;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (data_valid && frame_err) bad_strobe++;
    if (!ena && (data_valid || frame_err)) bad_strobe++;
    if (frame_err) ferr_seen++;
    if (data_valid) begin
      valid_cyc = cyc;
      if (exp_q.size() == 0) extra_valid++;
      else chk("rx_byte", int'(data_out), int'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] mk(input logic [7:0] d, input logic s);
    return {s, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [9:0] line, input int n);
    for (int i = 0; i < n; i++) begin
      rx = line[i];
      if (i == 9) stop_cyc = cyc;
      tick(CPB);
    end
  endtask

  // Expectation from the framing rules: good stop bit delivers the byte, bad one flags an error.
  task automatic model_frame(input logic [7:0] d, input logic s);
    if (s) begin
      exp_q.push_back(d);
      last_good = d;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic s, input int gap_bits);
    send_bits(mk(d, s), 10);
    rx = 1'b1;
    tick(gap_bits * CPB);
  endtask

  task automatic checkpoint(input string tag);
    rx = 1'b1;
    tick(2 * CPB);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_ferr_cnt"}, ferr_seen, exp_ferr);
    chk({tag, "_data_out"}, int'(data_out), int'(last_good));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_extra_valid"}, extra_valid, 0);
    chk({tag, "_strobe_rules"}, bad_strobe, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int lat;

    rst_n = 1'b0;
    ena   = 1'b1;
    rx    = 1'b1;
    last_good = 8'h00;
    #1;
    tick(5);
    chk("reset_data_out", int'(data_out), 8'h00);
    chk("reset_valid", int'(data_valid), 0);
    chk("reset_ferr", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(2);

    vecs[0] = '{d: 8'hA5, stop: 1'b1, gap_bits: 2, exp_valid: 1'b1, exp_byte: 8'hA5};
    vecs[1] = '{d: 8'h00, stop: 1'b1, gap_bits: 0, exp_valid: 1'b1, exp_byte: 8'h00};
    vecs[2] = '{d: 8'hFF, stop: 1'b1, gap_bits: 0, exp_valid: 1'b1, exp_byte: 8'hFF};
    vecs[3] = '{d: 8'h3C, stop: 1'b1, gap_bits: 2, exp_valid: 1'b1, exp_byte: 8'h3C};
    vecs[4] = '{d: 8'hC3, stop: 1'b0, gap_bits: 2, exp_valid: 1'b0, exp_byte: 8'h3C};
    vecs[5] = '{d: 8'h96, stop: 1'b1, gap_bits: 1, exp_valid: 1'b1, exp_byte: 8'h96};

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].exp_valid) begin
        exp_q.push_back(vecs[i].exp_byte);
        last_good = vecs[i].exp_byte;
      end else begin
        exp_ferr++;
      end
      drive_frame(vecs[i].d, vecs[i].stop, vecs[i].gap_bits);
      if (i == 0) begin
        lat = valid_cyc - stop_cyc;
        chk("latency_in_window", int'(lat >= HALF + 1 && lat <= HALF + 4), 1);
        chk("a5_data_out", int'(data_out), 8'hA5);
        chk("a5_busy_idle", int'(busy), 0);
      end
    end
    checkpoint("table");

    // Short low glitch must be rejected at mid start bit.
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3 * CPB);
    checkpoint("glitch");
    model_frame(8'h5A, 1'b1);
    drive_frame(8'h5A, 1'b1, 1);
    checkpoint("after_glitch");

    // Framing error followed by a held break.
    model_frame(8'h81, 1'b0);
    send_bits(mk(8'h81, 1'b0), 10);
    rx = 1'b0;
    tick(30);
    chk("break_busy_hold", int'(busy), 1);
    chk("break_ferr_cnt", ferr_seen, exp_ferr);
    chk("break_data_out", int'(data_out), int'(last_good));
    rx = 1'b1;
    tick(4);
    chk("break_release_busy", int'(busy), 0);
    model_frame(8'h42, 1'b1);
    drive_frame(8'h42, 1'b1, 1);
    checkpoint("after_break");

    // Reset during bit 4 discards the partial byte.
    send_bits(mk(8'h77, 1'b1), 5);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    last_good = 8'h00;
    tick(2 * CPB);
    chk("midreset_data_out", int'(data_out), 8'h00);
    checkpoint("midreset");
    model_frame(8'h11, 1'b1);
    drive_frame(8'h11, 1'b1, 1);
    checkpoint("after_reset");

    // Dropping ena during bit 3 forces idle on the next edge.
    send_bits(mk(8'h99, 1'b1), 4);
    rx = 1'b1;
    tick(3);
    ena = 1'b0;
    tick(1);
    chk("ena_drop_busy", int'(busy), 0);
    tick(CPB);
    ena = 1'b1;
    checkpoint("ena_drop");

    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       s;
      int         gap;
      d   = 8'($urandom);
      s   = ($urandom_range(0, 7) != 0);
      gap = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      model_frame(d, s);
      drive_frame(d, s, gap);
    end
    checkpoint("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
